// File: rtl/fp_add_sub_param.sv
// ---------------------------------------------------------------------------
// fp_add_sub_param
//
// Multi-cycle floating-point adder/subtractor for IEEE-754-style operands with
// configurable exponent (EXP_W) and stored mantissa (MAN_W) widths. Rounding
// is round-to-nearest-even. Subnormal inputs are flushed to signed zero.
//
// Optional feature macro: FP_SPECIALS_EN
//   defined   : all-ones exponent decodes as Inf/NaN; NaN inputs and
//               effective Inf - Inf give a canonical quiet NaN with inv=1.
//   undefined : all-ones exponent is an ordinary finite value; inv stays 0.
//
// Ports
//   clk      in  rising-edge clock
//   reset_n  in  synchronous active-low reset
//   start    in  operation request, sampled only while idle
//   op       in  0: a+b, 1: a-b
//   a, b     in  operands {sign, exp[EXP_W-1:0], man[MAN_W-1:0]}
//   result   out registered result, held until the next completion
//   done     out one-cycle completion pulse
//   busy     out high whenever the unit is not idle
//   ovf      out result saturated to +/-Inf (held)
//   unf      out nonzero result flushed to +/-0 (held)
//   inv      out invalid operation, NaN produced (held)
// ---------------------------------------------------------------------------
module fp_add_sub_param #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   op,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic [EXP_W+MAN_W:0]   result,
   output logic                   done,
   output logic                   busy,
   output logic                   ovf,
   output logic                   unf,
   output logic                   inv
);

   localparam int W  = EXP_W + MAN_W + 1;       // packed operand width
   localparam int MW = MAN_W + 1;               // mantissa with hidden bit
   localparam int SW = MAN_W + 5;               // {carry, mantissa, G, R, S}
   localparam int XW = EXP_W + $clog2(MAN_W + 2) + 2; // signed working exponent

   localparam logic [EXP_W-1:0]    EXP_ONES = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0]    EXP_ZERO = {EXP_W{1'b0}};
   localparam logic [MAN_W-1:0]    MAN_ZERO = {MAN_W{1'b0}};
   localparam logic [MAN_W-1:0]    QNAN_MAN = {1'b1, {(MAN_W-1){1'b0}}};
   localparam logic signed [XW-1:0] X_ONE  = {{(XW-1){1'b0}}, 1'b1};
   localparam logic signed [XW-1:0] X_ZERO = {XW{1'b0}};
   localparam logic signed [XW-1:0] X_ALL1 = {{(XW-EXP_W){1'b0}}, {EXP_W{1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_ALIGN  = 3'd2,
      S_ADD    = 3'd3,
      S_NORM   = 3'd4,
      S_ROUND  = 3'd5,
      S_PACK   = 3'd6
   } state_t;

   // Exponent field of zero encodes zero; subnormals are flushed the same way.
   function automatic logic exp_is_zero(input logic [W-1:0] x);
      return (x[W-2:MAN_W] == EXP_ZERO);
   endfunction

   state_t                 state_q, state_d;
   logic [W-1:0]           a_q, a_d, b_q, b_d;
   logic                   op_q, op_d;
   logic                   sign_q, sign_d;
   logic                   eff_sub_q, eff_sub_d;
   logic signed [XW-1:0]   exp_q, exp_d;
   logic [EXP_W-1:0]       shift_q, shift_d;
   logic [MW-1:0]          m_big_q, m_big_d;
   logic [MW-1:0]          m_small_q, m_small_d;
   logic [MAN_W+3:0]       small_al_q, small_al_d;
   logic [SW-1:0]          sum_q, sum_d;
   logic [MAN_W-1:0]       man_q, man_d;
   logic                   zero_q, zero_d;
   logic                   bypass_q, bypass_d;
   logic [W-1:0]           byp_res_q, byp_res_d;
   logic                   byp_inv_q, byp_inv_d;
   logic [W-1:0]           result_q, result_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;
   logic                   ovf_q, ovf_d;
   logic                   unf_q, unf_d;
   logic                   inv_q, inv_d;

   // Combinational scratch values
   logic                   sa_s, sb_s, a_z_s, b_z_s, a_ge_s, take_byp_s, inc_s;
   logic [EXP_W-1:0]       ea_s, eb_s;
   logic [MAN_W-1:0]       ma_s, mb_s;
   logic [2*MAN_W+3:0]     wide_s;
   logic [SW-1:0]          big_ext_s, small_ext_s, sum_s;
   logic [MW:0]            man_r_s;
`ifdef FP_SPECIALS_EN
   logic                   a_sp_s, b_sp_s, a_nan_s, b_nan_s;
`endif

   // Next-state and datapath computation for every FSM state.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      sign_d     = sign_q;
      eff_sub_d  = eff_sub_q;
      exp_d      = exp_q;
      shift_d    = shift_q;
      m_big_d    = m_big_q;
      m_small_d  = m_small_q;
      small_al_d = small_al_q;
      sum_d      = sum_q;
      man_d      = man_q;
      zero_d     = zero_q;
      bypass_d   = bypass_q;
      byp_res_d  = byp_res_q;
      byp_inv_d  = byp_inv_q;
      result_d   = result_q;
      done_d     = 1'b0;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      inv_d      = inv_q;

      // Operand fields; b's sign is folded with the opcode.
      sa_s        = a_q[W-1];
      sb_s        = b_q[W-1] ^ op_q;
      ea_s        = a_q[W-2:MAN_W];
      eb_s        = b_q[W-2:MAN_W];
      ma_s        = a_q[MAN_W-1:0];
      mb_s        = b_q[MAN_W-1:0];
      a_z_s       = exp_is_zero(a_q);
      b_z_s       = exp_is_zero(b_q);
      a_ge_s      = (a_q[W-2:0] >= b_q[W-2:0]);
      take_byp_s  = 1'b0;
      wide_s      = {m_small_q, {(MAN_W+3){1'b0}}} >> shift_q;
      big_ext_s   = {1'b0, m_big_q, 3'b000};
      small_ext_s = {1'b0, small_al_q};
      sum_s       = eff_sub_q ? (big_ext_s - small_ext_s) : (big_ext_s + small_ext_s);
      inc_s       = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
      man_r_s     = {1'b0, sum_q[SW-2:3]} + {{MW{1'b0}}, inc_s};
`ifdef FP_SPECIALS_EN
      a_sp_s      = (ea_s == EXP_ONES);
      b_sp_s      = (eb_s == EXP_ONES);
      a_nan_s     = a_sp_s & (ma_s != MAN_ZERO);
      b_nan_s     = b_sp_s & (mb_s != MAN_ZERO);
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d       = a;
               b_d       = b;
               op_d      = op;
               bypass_d  = 1'b0;
               zero_d    = 1'b0;
               byp_inv_d = 1'b0;
               state_d   = S_UNPACK;
            end else begin
               state_d   = S_IDLE;
            end
         end

         S_UNPACK: begin
`ifdef FP_SPECIALS_EN
            if (a_nan_s || b_nan_s || (a_sp_s && b_sp_s && (sa_s != sb_s))) begin
               take_byp_s = 1'b1;
               byp_res_d  = {1'b0, EXP_ONES, QNAN_MAN};
               byp_inv_d  = 1'b1;
            end else if (a_sp_s) begin
               take_byp_s = 1'b1;
               byp_res_d  = a_q;
            end else if (b_sp_s) begin
               take_byp_s = 1'b1;
               byp_res_d  = {sb_s, eb_s, mb_s};
            end else begin
               take_byp_s = 1'b0;
            end
`endif
            if (take_byp_s) begin
               bypass_d = 1'b1;
            end else if (a_z_s && b_z_s) begin
               // -0 only when both effective operands are -0
               bypass_d  = 1'b1;
               byp_res_d = {sa_s & sb_s, EXP_ZERO, MAN_ZERO};
            end else if (a_z_s) begin
               bypass_d  = 1'b1;
               byp_res_d = {sb_s, eb_s, mb_s};
            end else if (b_z_s) begin
               bypass_d  = 1'b1;
               byp_res_d = a_q;
            end else begin
               bypass_d = 1'b0;
            end

            // Larger magnitude supplies sign and provisional exponent.
            if (a_ge_s) begin
               sign_d    = sa_s;
               exp_d     = {{(XW-EXP_W){1'b0}}, ea_s};
               shift_d   = ea_s - eb_s;
               m_big_d   = {1'b1, ma_s};
               m_small_d = {1'b1, mb_s};
            end else begin
               sign_d    = sb_s;
               exp_d     = {{(XW-EXP_W){1'b0}}, eb_s};
               shift_d   = eb_s - ea_s;
               m_big_d   = {1'b1, mb_s};
               m_small_d = {1'b1, ma_s};
            end
            eff_sub_d = sa_s ^ sb_s;

            if (bypass_d) begin
               state_d = S_PACK;
            end else begin
               state_d = S_ALIGN;
            end
         end

         S_ALIGN: begin
            // Beyond MAN_W+2 positions even the hidden bit lands past R.
            if ({{(32-EXP_W){1'b0}}, shift_q} >= 32'(MAN_W + 3)) begin
               small_al_d = {{(MAN_W+3){1'b0}}, 1'b1};
            end else begin
               small_al_d = {wide_s[2*MAN_W+3:MAN_W+3], wide_s[MAN_W+2],
                             wide_s[MAN_W+1], |wide_s[MAN_W:0]};
            end
            state_d = S_ADD;
         end

         S_ADD: begin
            // Subtraction is always big - small, so the result is never negative.
            sum_d = sum_s;
            if (sum_s == {SW{1'b0}}) begin
               zero_d  = 1'b1;
               sign_d  = 1'b0;
               state_d = S_ROUND;
            end else begin
               state_d = S_NORM;
            end
         end

         S_NORM: begin
            if (sum_q[SW-1]) begin
               // Carry out: old LSB becomes G, old G becomes R, R|S collapse to S.
               sum_d   = {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
               exp_d   = exp_q + X_ONE;
               state_d = S_ROUND;
            end else if (!sum_q[SW-2]) begin
               // One left shift per cycle; G enters the LSB, S stays sticky.
               sum_d   = {1'b0, sum_q[SW-3:0], sum_q[0]};
               exp_d   = exp_q - X_ONE;
               state_d = S_NORM;
            end else begin
               state_d = S_ROUND;
            end
         end

         S_ROUND: begin
            if (man_r_s[MW]) begin
               man_d = man_r_s[MAN_W:1];
               exp_d = exp_q + X_ONE;
            end else begin
               man_d = man_r_s[MAN_W-1:0];
            end
            state_d = S_PACK;
         end

         S_PACK: begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            inv_d = 1'b0;
            if (bypass_q) begin
               result_d = byp_res_q;
               inv_d    = byp_inv_q;
            end else if (zero_q) begin
               result_d = {sign_q, EXP_ZERO, MAN_ZERO};
            end else if (exp_q >= X_ALL1) begin
               result_d = {sign_q, EXP_ONES, MAN_ZERO};
               ovf_d    = 1'b1;
            end else if (exp_q <= X_ZERO) begin
               result_d = {sign_q, EXP_ZERO, MAN_ZERO};
               unf_d    = 1'b1;
            end else begin
               result_d = {sign_q, exp_q[EXP_W-1:0], man_q};
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         a_q        <= {W{1'b0}};
         b_q        <= {W{1'b0}};
         op_q       <= 1'b0;
         sign_q     <= 1'b0;
         eff_sub_q  <= 1'b0;
         exp_q      <= X_ZERO;
         shift_q    <= EXP_ZERO;
         m_big_q    <= {MW{1'b0}};
         m_small_q  <= {MW{1'b0}};
         small_al_q <= {(MAN_W+4){1'b0}};
         sum_q      <= {SW{1'b0}};
         man_q      <= MAN_ZERO;
         zero_q     <= 1'b0;
         bypass_q   <= 1'b0;
         byp_res_q  <= {W{1'b0}};
         byp_inv_q  <= 1'b0;
         result_q   <= {W{1'b0}};
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         inv_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         sign_q     <= sign_d;
         eff_sub_q  <= eff_sub_d;
         exp_q      <= exp_d;
         shift_q    <= shift_d;
         m_big_q    <= m_big_d;
         m_small_q  <= m_small_d;
         small_al_q <= small_al_d;
         sum_q      <= sum_d;
         man_q      <= man_d;
         zero_q     <= zero_d;
         bypass_q   <= bypass_d;
         byp_res_q  <= byp_res_d;
         byp_inv_q  <= byp_inv_d;
         result_q   <= result_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         inv_q      <= inv_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;
   assign busy   = busy_q;
   assign ovf    = ovf_q;
   assign unf    = unf_q;
   assign inv    = inv_q;

endmodule

// File: tb/tb_fp_add_sub_param.sv
// ---------------------------------------------------------------------------
// tb_fp_add_sub_param
//
// Directed self-checking bench for fp_add_sub_param with the default binary32
// geometry. Expected results, flags and latencies are hand-computed constants.
// Expectations for Inf - Inf follow FP_SPECIALS_EN.
// ---------------------------------------------------------------------------
module tb_fp_add_sub_param;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] result;
   logic        done;
   logic        busy;
   logic        ovf;
   logic        unf;
   logic        inv;

   int n_checks;
   int n_errors;

   fp_add_sub_param #(.EXP_W(8), .MAN_W(23)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .result  (result),
      .done    (done),
      .busy    (busy),
      .ovf     (ovf),
      .unf     (unf),
      .inv     (inv)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one operation and check result, flags, busy and done latency.
   // With poke set, start is raised again with junk operands while busy.
   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic opv, input logic [31:0] e_res, input logic e_ovf,
                         input logic e_unf, input logic e_inv, input int e_lat,
                         input logic poke);
      int edges;
      @(negedge clk);
      a     = av;
      b     = bv;
      op    = opv;
      start = 1'b1;
      @(posedge clk);
      #1;
      edges = 1;
      start = 1'b0;
      a     = 32'hDEADBEEF;
      b     = 32'h12345678;
      op    = ~opv;
      check_value({tag, "_busy1"}, {31'd0, busy}, 32'd1);
      while (done !== 1'b1 && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
         start = (poke && edges == 2) ? 1'b1 : 1'b0;
      end
      start = 1'b0;
      check_value({tag, "_done"}, {31'd0, done}, 32'd1);
      check_value({tag, "_lat"}, 32'(edges), 32'(e_lat));
      check_value({tag, "_res"}, result, e_res);
      check_value({tag, "_flags"}, {29'd0, ovf, unf, inv}, {29'd0, e_ovf, e_unf, e_inv});
      check_value({tag, "_busy0"}, {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      check_value({tag, "_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int done_cnt;
      n_checks = 0;
      n_errors = 0;
      reset_n  = 1'b0;
      start    = 1'b0;
      op       = 1'b0;
      a        = 32'd0;
      b        = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_value("rst_out", {result[31:0]}, 32'd0);
      check_value("rst_ctl", {27'd0, done, busy, ovf, unf, inv}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      run_op("add_1_2",    32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0, 7, 1'b0);
      run_op("sub_norm",   32'h3FC00000, 32'h3F400000, 1'b1, 32'h3F400000, 1'b0, 1'b0, 1'b0, 8, 1'b0);
      run_op("sub_cancel", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 6, 1'b0);
      run_op("rne_tie",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0, 7, 1'b0);
      run_op("rne_up",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b0, 7, 1'b0);
      run_op("rnd_carry",  32'h3FFFFFFF, 32'h33800001, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 7, 1'b0);
      run_op("add_carry",  32'h3FFFFFFF, 32'h34000000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 7, 1'b0);
      run_op("mixed_sign", 32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b0, 1'b0, 8, 1'b0);
      run_op("unf",        32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 30, 1'b0);
      run_op("byp_x_0",    32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB, 1'b0, 1'b0, 1'b0, 3, 1'b0);
      run_op("byp_0_sub",  32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0, 1'b0, 1'b0, 3, 1'b0);
      run_op("byp_sub_fl", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0, 3, 1'b0);
      run_op("byp_nz_nz",  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0, 3, 1'b0);
      run_op("byp_nz_pz",  32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 3, 1'b0);
`ifdef FP_SPECIALS_EN
      run_op("inf_m_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 3, 1'b0);
`else
      run_op("inf_m_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 6, 1'b0);
`endif
      run_op("poke_busy",  32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0, 7, 1'b1);
      run_op("ovf",        32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0, 7, 1'b0);

      // Abort a long normalisation with reset; outputs must clear, no done.
      @(negedge clk);
      a     = 32'h00800000;
      b     = 32'h00800001;
      op    = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check_value("mid_rst_res", result, 32'd0);
      check_value("mid_rst_ctl", {27'd0, done, busy, ovf, unf, inv}, 32'd0);
      @(negedge clk);
      reset_n  = 1'b1;
      done_cnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) done_cnt++;
      end
      check_value("mid_rst_nodone", 32'(done_cnt), 32'd0);
      run_op("after_rst",  32'h3FC00000, 32'h3F400000, 1'b1, 32'h3F400000, 1'b0, 1'b0, 1'b0, 8, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
